ppm_frame_generator: RTL and testbench
======================================

// Module: ppm_frame_generator
// PURPOSE
// - Multi-channel RC PPM encoder: serialises NUM_CH 8-bit channel values into one PPM stream on ppm_out.
// - Transmit-side counterpart of the RC pulse receivers.
// - Drives the trainer/buddy-box port and external flight controllers from register values set over the peripheral bus.
// - Time base is clk_255kHz: 255 ticks = 1 ms.
// PARAMETERS
// - NUM_CH       8     channels per frame (1..12)
// - GAP_TICKS    77    low separator pulse length in ticks (~0.3 ms); 1..254
// - FRAME_TICKS  5738  frame period in ticks (~22.5 ms)
// - FS_TICKS     25500 failsafe timeout in ticks (100 ms); used only with PPM_FAILSAFE_EN
// PORTS
// - clk_255kHz  in   1         255 kHz system tick clock
// - reset       in   1         synchronous, active-high reset
// - width_in    in   8*NUM_CH  channel i at [8i+7:8i]; 0 = 1 ms slot, 255 = 2 ms slot
// - enable      in   1         1 = generate frames continuously
// - update      in   1         1-cycle strobe: host refreshed width_in (failsafe feed)
// - ppm_out     out  1         PPM stream; idle/mark high, separators low
// - frame_start out  1         1-cycle pulse on first cycle of each frame
// - busy        out  1         high while a frame is in progress
// - failsafe    out  1         1 = current frame carries neutral values (0 when macro off)
// BEHAVIOUR
// - Clock and reset: single clock domain. reset is synchronous, active-high.
// - Reset values: ppm_out=1, frame_start=0, busy=0, failsafe=0, state=IDLE, all counters 0, latched widths 8'd127.
// - FSM states: IDLE -> GAP -> MARK -> (GAP/MARK per channel) -> ENDGAP -> SYNC -> GAP or IDLE.
// - IDLE: ppm_out=1. When enable=1 is sampled, the next cycle enters GAP for ch0.
//   - On that entry cycle: frame_start=1, busy=1, ppm_out=0.
//   - All NUM_CH widths are latched atomically in the same cycle.
// - GAP: ppm_out=0 for exactly GAP_TICKS cycles.
// - MARK: ppm_out=1 for (255+w-GAP_TICKS) cycles, where w is the latched width of that channel.
//   - Slot length (falling edge to falling edge) = 255+w cycles exactly.
//   - Slot arithmetic is done at 10 bits, with no truncation of 255+w.
// - After the last channel's MARK: ENDGAP, low for GAP_TICKS cycles (NUM_CH+1 falling edges per frame).
// - SYNC: high until the frame counter reaches FRAME_TICKS-1.
//   - Frame counter is 13 bits, cleared at frame start.
//   - Period between frame_start pulses = FRAME_TICKS exactly while enable stays 1.
// - End of SYNC:
//   - enable=1: next cycle is GAP of the next frame (back-to-back, no idle cycle).
//   - enable=0: go to IDLE; busy=0 on the IDLE cycle.
// - enable falling mid-frame: current frame completes unchanged; never truncate a frame or emit a runt pulse.
// - width_in changes mid-frame are ignored until the next frame-start latch.
// - reset mid-frame: next cycle ppm_out=1, IDLE, latched widths 127, busy=0.
// - Elaboration $error unless GAP_TICKS<255 and FRAME_TICKS >= NUM_CH*510+GAP_TICKS+255 (sync >= 1 ms).
// CONFIGURATION
// - PPM_FAILSAFE_EN defined:
//   - 15-bit watchdog counts cycles since the last update strobe and saturates at FS_TICKS.
//   - If the count == FS_TICKS at a frame-start latch: latch 8'd127 for every channel and set failsafe=1 for that frame.
//   - Otherwise latch width_in and set failsafe=0.
//   - update clears the watchdog; recovery takes effect at the next frame start.
//   - update coincident with frame start counts as fresh.
// - PPM_FAILSAFE_EN undefined:
//   - No watchdog logic; update is ignored.
//   - failsafe tied 0; width_in is always latched.
// TESTING
// - T1: reset, NUM_CH=8, all widths 0, enable=1
//   -> falling edges at cycles 0,255,...,2040; low 77 cycles each; frame_start again at 5738.
// - T2: ch0=255, others 0 -> ch0 slot 510 cycles (433 high); ch1 falling edge at cycle 510.
// - T3: change width_in at cycle 300 of a frame -> current frame unchanged; new values take effect from the next frame_start.
// - T4: drop enable at cycle 1000 -> frame completes through SYNC; ppm_out held 1; busy=0 at cycle 5738; no further frame_start.
// - T5: assert reset during a MARK -> ppm_out=1 next cycle, busy=0; re-enable gives all slots 382 cycles (w=127).
// - T6 (PPM_FAILSAFE_EN): widths 0, no update for 25500 cycles
//   -> next frame slots 382 cycles, failsafe=1.
//   -> one update strobe -> following frame slots 255 cycles, failsafe=0.

Source files
------------

// File: rtl/ppm_frame_generator_if.sv
// ppm_frame_generator_if: host/encoder bundle for the PPM frame generator
// Ports: width_in, enable, update (host -> encoder); ppm_out, frame_start, busy, failsafe (encoder -> host)
interface ppm_frame_generator_if #(
  parameter int NUM_CH = 8
);
  logic [8*NUM_CH-1:0] width_in;
  logic                enable;
  logic                update;
  logic                ppm_out;
  logic                frame_start;
  logic                busy;
  logic                failsafe;
  modport master (
    output width_in, enable, update,
    input  ppm_out, frame_start, busy, failsafe
  );
  modport slave (
    input  width_in, enable, update,
    output ppm_out, frame_start, busy, failsafe
  );
endinterface

// File: rtl/ppm_frame_generator.sv
// ppm_frame_generator: serialises NUM_CH 8-bit channel widths into a PPM stream (255 ticks = 1 ms)
// Ports: clk_255kHz tick clock, reset sync active-high, bus (slave) carrying width_in/enable/update in and ppm_out/frame_start/busy/failsafe out
// Option: define PPM_FAILSAFE_EN to add the update watchdog that substitutes neutral widths
module ppm_frame_generator #(
  parameter int NUM_CH      = 8,
  parameter int GAP_TICKS   = 77,
  parameter int FRAME_TICKS = 5738,
  parameter int FS_TICKS    = 25500
) (
  input logic                 clk_255kHz,
  input logic                 reset,
  ppm_frame_generator_if.slave bus
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [9:0]    GAP_END   = 10'(GAP_TICKS - 1);
  localparam logic [12:0]   FRAME_END = 13'(FRAME_TICKS - 1);
  if (NUM_CH < 1 || NUM_CH > 12 || GAP_TICKS < 1 || GAP_TICKS > 254 ||
      FRAME_TICKS < NUM_CH*510 + GAP_TICKS + 255 || FRAME_TICKS > 8192 ||
      FS_TICKS < 1 || FS_TICKS > 32767) begin : g_cfg_check
    $error("ppm_frame_generator: illegal parameter combination");
  end
  typedef enum logic [2:0] {IDLE, GAP, MARK, ENDGAP, SYNC} state_e;
  state_e        state_q;
  logic [CW-1:0] ch_q;
  logic [9:0]    slot_q;
  logic [12:0]   frame_q;
  logic [7:0]    wid_q [NUM_CH];
  logic          ppm_q, start_q, busy_q, fs_q;
  logic          frame_end, go, fresh;
  logic [9:0]    mark_end;
  // slot_q counts from the falling edge, so the mark ends at slot 255+w-1
  always_comb begin
    frame_end = state_q == SYNC && frame_q == FRAME_END;
    go        = bus.enable && (state_q == IDLE || frame_end);
    mark_end  = 10'd254 + {2'b00, wid_q[ch_q]};
  end
`ifdef PPM_FAILSAFE_EN
  logic [14:0] wd_q;
  // an update on the latch cycle itself counts as fresh data
  always_comb fresh = bus.update || wd_q != 15'(FS_TICKS);
  always_ff @(posedge clk_255kHz) begin
    if (reset || bus.update) wd_q <= '0;
    else if (wd_q != 15'(FS_TICKS)) wd_q <= wd_q + 15'd1;
  end
`else
  always_comb fresh = 1'b1;
`endif
  always_ff @(posedge clk_255kHz) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      ppm_q   <= 1'b1;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fs_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) wid_q[i] <= 8'd127;
    end else begin
      start_q <= go;
      if (go) begin
        state_q <= GAP;
        ch_q    <= '0;
        slot_q  <= '0;
        frame_q <= '0;
        ppm_q   <= 1'b0;
        busy_q  <= 1'b1;
        fs_q    <= ~fresh;
        for (int i = 0; i < NUM_CH; i++) wid_q[i] <= fresh ? bus.width_in[8*i +: 8] : 8'd127;
      end else begin
        if (state_q != IDLE) frame_q <= frame_q + 13'd1;
        if (state_q inside {GAP, MARK, ENDGAP}) slot_q <= slot_q + 10'd1;
        case (state_q)
          GAP: if (slot_q == GAP_END) begin
            state_q <= MARK;
            ppm_q   <= 1'b1;
          end
          MARK: if (slot_q == mark_end) begin
            state_q <= ch_q == LAST_CH ? ENDGAP : GAP;
            ch_q    <= ch_q == LAST_CH ? ch_q : ch_q + 1'b1;
            slot_q  <= '0;
            ppm_q   <= 1'b0;
          end
          ENDGAP: if (slot_q == GAP_END) begin
            state_q <= SYNC;
            ppm_q   <= 1'b1;
          end
          SYNC: if (frame_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            frame_q <= '0;
            slot_q  <= '0;
            ch_q    <= '0;
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.ppm_out     = ppm_q;
  assign bus.frame_start = start_q;
  assign bus.busy        = busy_q;
  assign bus.failsafe    = fs_q;
endmodule

// File: tb/tb_ppm_frame_generator.sv
// tb_ppm_frame_generator: vector table plus frame scoreboard for ppm_frame_generator
module tb_ppm_frame_generator;
  localparam int NUM_CH = 8;
  localparam int GAP    = 77;
  localparam int FRAME  = 5738;
  localparam int FS     = 25500;
  typedef struct {
    logic [8*NUM_CH-1:0] w;
    int                  end_c;
  } vec_t;
  typedef struct {
    int edge_c [NUM_CH+1];
    int end_c;
    bit fs;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_starts = 0;
  exp_t exp_q [$];
  vec_t tbl [6];
  ppm_frame_generator_if #(.NUM_CH(NUM_CH)) bus ();
  ppm_frame_generator #(
    .NUM_CH(NUM_CH), .GAP_TICKS(GAP), .FRAME_TICKS(FRAME), .FS_TICKS(FS)
  ) dut (
    .clk_255kHz(clk),
    .reset     (reset),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic exp_t mk(logic [8*NUM_CH-1:0] w, int end_c, bit fs);
    exp_t e;
    e.edge_c[0] = 0;
    for (int k = 0; k < NUM_CH; k++) e.edge_c[k+1] = e.edge_c[k] + 255 + int'(w[8*k +: 8]);
    e.end_c = end_c;
    e.fs    = fs;
    return e;
  endfunction
  task automatic load(logic [8*NUM_CH-1:0] w);
    bus.width_in = w;
    bus.update   = 1'b1;
    @(negedge clk);
    bus.update   = 1'b0;
  endtask
  task automatic wait_start(int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < lim);
    if (!bus.frame_start) chk("start_timeout", 0, 1);
  endtask
  task automatic wait_empty(int lim);
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("frames_pending", exp_q.size(), 0);
  endtask
  // monitor: measures falling edges and low widths per frame, pops the scoreboard at frame end
  initial begin
    int   mcyc, nedge, nlow, prev, bad, lowbad;
    bit   have_prev, gap_seen;
    int   edges [NUM_CH+1];
    int   lows [NUM_CH+1];
    exp_t e;
    mcyc = 0; nedge = 0; nlow = 0; prev = 1; have_prev = 0; gap_seen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        nedge = 0; nlow = 0; have_prev = 0; prev = 1;
        continue;
      end
      if (!bus.busy) gap_seen = 1;
      if (bus.frame_start) begin
        n_starts++;
        if (have_prev && !gap_seen) chk("period", mcyc + 1, FRAME);
        have_prev = 1; gap_seen = 0; mcyc = 0; nedge = 0; nlow = 0;
        chk("entry_ppm", int'(bus.ppm_out), 0);
        chk("entry_busy", int'(bus.busy), 1);
        if (exp_q.size() == 0) chk("frame_expected", 0, 1);
        else chk("failsafe", int'(bus.failsafe), int'(exp_q[0].fs));
      end else mcyc++;
      if (prev == 1 && bus.ppm_out == 1'b0 && nedge <= NUM_CH) begin
        edges[nedge] = mcyc;
        nedge++;
      end
      if (prev == 0 && bus.ppm_out == 1'b1 && nedge > 0 && nlow <= NUM_CH) begin
        lows[nlow] = mcyc - edges[nedge-1];
        nlow++;
        if (nlow == NUM_CH + 1 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          bad = -1;
          for (int k = 0; k <= NUM_CH; k++) if (bad < 0 && edges[k] != e.edge_c[k]) bad = k;
          chk("edge_first_bad_idx", bad, -1);
          chk("last_edge", edges[NUM_CH], e.end_c);
          lowbad = GAP;
          for (int k = 0; k <= NUM_CH; k++) if (lows[k] != GAP) lowbad = lows[k];
          chk("low_len", lowbad, GAP);
        end
      end
      prev = int'(bus.ppm_out);
    end
  end
  initial begin
    int starts;
    tbl[0] = '{64'h0000000000000000, 2040};
    tbl[1] = '{64'h00000000000000FF, 2295};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 4080};
    tbl[3] = '{64'h7868584838281808, 2552};
    tbl[4] = '{64'h7F7F7F7F7F7F7F7F, 3056};
    tbl[5] = '{64'hFF00FF00FF00FF00, 3060};
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.update = 1'b0;
    bus.width_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_ppm", int'(bus.ppm_out), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_start", int'(bus.frame_start), 0);
    chk("reset_failsafe", int'(bus.failsafe), 0);
    reset = 1'b0;
    load(tbl[0].w);
    exp_q.push_back(mk(tbl[0].w, tbl[0].end_c, 1'b0));
    bus.enable = 1'b1;
    // each new vector is applied at cycle 300 of the running frame and must only show up in the next one
    for (int i = 1; i < 6; i++) begin
      wait_start(FRAME + 10);
      repeat (300) @(negedge clk);
      load(tbl[i].w);
      exp_q.push_back(mk(tbl[i].w, tbl[i].end_c, 1'b0));
    end
    wait_start(FRAME + 10);
    repeat (1000) @(negedge clk);
    bus.enable = 1'b0;
    repeat (FRAME - 1 - 1000) @(negedge clk);
    chk("t4_busy_last", int'(bus.busy), 1);
    chk("t4_ppm_last", int'(bus.ppm_out), 1);
    @(negedge clk);
    chk("t4_busy_idle", int'(bus.busy), 0);
    chk("t4_ppm_idle", int'(bus.ppm_out), 1);
    chk("t4_start_idle", int'(bus.frame_start), 0);
    starts = n_starts;
    repeat (6000) @(negedge clk);
    chk("t4_no_restart", n_starts, starts);
    chk("t4_pending", exp_q.size(), 0);
    load({NUM_CH{8'd127}});
    exp_q.push_back(mk({NUM_CH{8'd127}}, 3056, 1'b0));
    bus.enable = 1'b1;
    wait_start(20);
    repeat (600) @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    chk("t5_ppm", int'(bus.ppm_out), 1);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_start", int'(bus.frame_start), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(mk({NUM_CH{8'd127}}, 3056, 1'b0));
    bus.enable = 1'b1;
    wait_empty(FRAME);
    bus.enable = 1'b0;
    repeat (FRAME) @(negedge clk);
    chk("t5_idle", int'(bus.busy), 0);
`ifdef PPM_FAILSAFE_EN
    bus.width_in = '0;
    repeat (FS + 100) @(negedge clk);
    exp_q.push_back(mk({NUM_CH{8'd127}}, 3056, 1'b1));
    bus.enable = 1'b1;
    wait_start(20);
    repeat (300) @(negedge clk);
    load('0);
    exp_q.push_back(mk('0, 2040, 1'b0));
    wait_start(FRAME + 10);
    bus.enable = 1'b0;
    wait_empty(FRAME);
    chk("t6_fs_clear", int'(bus.failsafe), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
